spi_burst_arbiter: RTL

- Round-robin arbiter and sequencer that shares one byte-wide SPI master engine among NUM_REQ requesters.
- Grants a whole multi-byte burst to one requester, drives that requester's dedicated active-low chip select, and feeds bytes to the engine one at a time.
- Returns each received byte to the owner and signals burst completion.
- Sits between client blocks (sensor readers, display drivers) and the SPI byte engine. The engine's own per-byte chip select is left unused; device select comes from this block.

---
 rtl/spi_burst_arbiter.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/spi_burst_arbiter.sv
// spi_burst_arbiter: round-robin owner of a shared byte-wide SPI engine.
// A granted requester keeps the engine and its own chip select for a whole
// burst of len+1 words. Words go to the engine one at a time, and each
// received word is handed back to the owner.
module spi_burst_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 4,
    parameter int CS_SETUP   = 4,
    parameter int CS_GAP     = 8
) (
    input  logic                            clk_in,
    input  logic                            rst_in,
    input  logic [NUM_REQ-1:0]              req_in,
    input  logic [NUM_REQ*LEN_WIDTH-1:0]    req_len_in,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   tx_data_in,
    output logic [NUM_REQ-1:0]              grant_out,
    output logic [NUM_REQ-1:0]              tx_ready_out,
    output logic [DATA_WIDTH-1:0]           rx_data_out,
    output logic [NUM_REQ-1:0]              rx_valid_out,
    output logic [NUM_REQ-1:0]              done_out,
    output logic [NUM_REQ-1:0]              cs_n_out,
    output logic [DATA_WIDTH-1:0]           spi_data_out,
    output logic                            spi_trigger_out,
    input  logic [DATA_WIDTH-1:0]           spi_data_in,
    input  logic                            spi_valid_in
);

    localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TMR_MAX = (CS_SETUP > CS_GAP) ? CS_SETUP : CS_GAP;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [TMR_W-1:0] SETUP_LOAD = TMR_W'(CS_SETUP - 1);
    localparam logic [TMR_W-1:0] GAP_LOAD   = TMR_W'(CS_GAP - 1);
    localparam logic [IDX_W-1:0] PTR_RESET  = IDX_W'(NUM_REQ - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SEND,
        S_WAIT,
        S_GAP
    } state_t;

    // Registered state and its next-state values.
    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       ptr_q, ptr_d;         // last owner; also current owner
    logic [NUM_REQ-1:0]     grant_q, grant_d;
    logic [NUM_REQ-1:0]     cs_n_q, cs_n_d;
    logic [LEN_WIDTH-1:0]   cnt_q, cnt_d;         // words still to send after the current one
    logic [TMR_W-1:0]       tmr_q, tmr_d;         // shared setup / gap countdown
    logic [DATA_WIDTH-1:0]  rx_data_q, rx_data_d;
    logic [NUM_REQ-1:0]     rx_valid_q, rx_valid_d;
    logic [NUM_REQ-1:0]     done_q, done_d;

    // Arbitration and owner-slice selection.
    logic                   win_found;
    logic [IDX_W-1:0]       win_idx;
    logic [IDX_W-1:0]       cand;
    logic [NUM_REQ-1:0]     win_onehot;
    logic [LEN_WIDTH-1:0]   win_len;
    logic [DATA_WIDTH-1:0]  owner_tx;

    // Round-robin search: first set request strictly after the last owner.
    always_comb begin
        win_found = 1'b0;
        win_idx   = ptr_q;
        cand      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((int'(ptr_q) + k) % NUM_REQ);
            if (!win_found && req_in[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign win_onehot = NUM_REQ'(1) << win_idx;

    // Pick the winner's length field and the current owner's tx word.
    always_comb begin
        win_len  = '0;
        owner_tx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_idx == IDX_W'(i)) begin
                win_len = req_len_in[i*LEN_WIDTH +: LEN_WIDTH];
            end
            if (ptr_q == IDX_W'(i)) begin
                owner_tx = tx_data_in[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Burst sequencer: next-state logic and the combinational engine strobes.
    always_comb begin
        // NOTE: every signal written here is given a default first, so no path leaves one unassigned and no latch is inferred.
        state_d         = state_q;
        ptr_d           = ptr_q;
        grant_d         = grant_q;
        cs_n_d          = cs_n_q;
        cnt_d           = cnt_q;
        tmr_d           = tmr_q;
        rx_data_d       = rx_data_q;
        rx_valid_d      = '0;
        done_d          = '0;
        tx_ready_out    = '0;
        spi_trigger_out = 1'b0;
        spi_data_out    = '0;

        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    ptr_d   = win_idx;
                    grant_d = win_onehot;
                    cs_n_d  = ~win_onehot;
                    cnt_d   = win_len;
                    tmr_d   = SETUP_LOAD;
                    state_d = S_SETUP;
                end
            end

            S_SETUP: begin
                if (tmr_q == '0) begin
                    state_d = S_SEND;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end

            S_SEND: begin
                spi_trigger_out = 1'b1;
                spi_data_out    = owner_tx;
                tx_ready_out    = grant_q;
                state_d         = S_WAIT;
            end

            S_WAIT: begin
                if (spi_valid_in) begin
                    rx_data_d  = spi_data_in;
                    rx_valid_d = grant_q;
                    if (cnt_q == '0) begin
                        cs_n_d  = '1;
                        done_d  = grant_q;
                        grant_d = '0;
                        tmr_d   = GAP_LOAD;
                        state_d = S_GAP;
                    end else begin
                        cnt_d   = cnt_q - LEN_WIDTH'(1);
                        state_d = S_SEND;
                    end
                end
            end

            S_GAP: begin
                // Requests are deliberately ignored until the gap has elapsed.
                if (tmr_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register with synchronous reset; an aborted burst issues no done.
    always_ff @(posedge clk_in) begin
        // NOTE: non-blocking assignments so every register samples the pre-edge values of the others.
        if (rst_in) begin
            state_q    <= S_IDLE;
            ptr_q      <= PTR_RESET;
            grant_q    <= '0;
            cs_n_q     <= '1;
            cnt_q      <= '0;
            tmr_q      <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= '0;
            done_q     <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            grant_q    <= grant_d;
            cs_n_q     <= cs_n_d;
            cnt_q      <= cnt_d;
            tmr_q      <= tmr_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            done_q     <= done_d;
        end
    end

    assign grant_out    = grant_q;
    assign cs_n_out     = cs_n_q;
    assign rx_data_out  = rx_data_q;
    assign rx_valid_out = rx_valid_q;
    assign done_out     = done_q;

endmodule
